// File: rtl/dpc_pkg.sv
// dpc_pkg: shared DPC types, dekatron digit count and one-hot readout decode.
package dpc_pkg;
  localparam int DEK_DIGITS = 10;
  typedef enum logic [2:0] {IDLE, DECODE, DIR, PULSE_HI, PULSE_LO, DONE, FAULT} state_t;
  function automatic logic [3:0] onehot_to_bcd(input logic [DEK_DIGITS-1:0] v);
    logic [3:0] r;
    int n;
    r = 4'hF;
    n = 0;
    for (int i = 0; i < DEK_DIGITS; i++)
      if (v[i]) begin
        n++;
        r = 4'(i);
      end
    return (n == 1) ? r : 4'hF;
  endfunction
endpackage

// File: rtl/dekatron_pulse_gen.sv
// dekatron_pulse_gen: one step period of STEP_HIGH high, STEP_LOW low, SETTLE wait; Last marks its final cycle.
module dekatron_pulse_gen #(
  parameter int STEP_HIGH = 2,
  parameter int STEP_LOW  = 2,
  parameter int SETTLE    = 1
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Start,
  output logic Step,
  output logic Last
);
  localparam int PERIOD = STEP_HIGH + STEP_LOW + SETTLE;
  localparam int CW = $clog2(PERIOD + 1);
  logic [CW-1:0] cnt;
  logic active;
  assign Last = active && cnt == CW'(PERIOD - 1);
  // Start on the final cycle chains the next pulse with no gap
  always_ff @(posedge Clk)
    if (Rst) begin
      active <= 1'b0;
      cnt <= '0;
      Step <= 1'b0;
    end else if (Start) begin
      active <= 1'b1;
      cnt <= '0;
      Step <= 1'b1;
    end else if (active) begin
      active <= !Last;
      cnt <= Last ? '0 : cnt + 1'b1;
      Step <= !Last && (cnt + 1'b1 < CW'(STEP_HIGH));
    end
endmodule

// File: rtl/dekatron_seeker.sv
// dekatron_seeker: steps a dekatron along the shorter ring path to a BCD target.
// Define DEKATRON_SEEKER_VERIFY_EN to check the dekatron position after every step.
module dekatron_seeker
  import dpc_pkg::*;
#(
  parameter int STEP_HIGH = 2,
  parameter int STEP_LOW  = 2,
  parameter int SETTLE    = 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Request,
  input  logic [3:0]            Target,
  input  logic [DEK_DIGITS-1:0] DekIn,
  output logic                  Step,
  output logic                  Reverse,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error,
  output logic [3:0]            Value
);
  state_t state;
  logic [3:0] tgt, pos, cur, d, nxt;
  logic [2:0] k;
  logic last, ok, start, in_pulse;
  always_comb begin
    cur = onehot_to_bcd(DekIn);
    d = tgt - cur + ((tgt < cur) ? 4'd10 : 4'd0);
    nxt = Reverse ? ((pos == 4'd0) ? 4'd9 : pos - 4'd1) : ((pos == 4'd9) ? 4'd0 : pos + 4'd1);
  end
`ifdef DEKATRON_SEEKER_VERIFY_EN
  assign ok = DekIn == (10'd1 << nxt);
`else
  assign ok = 1'b1;
`endif
  assign in_pulse = state == PULSE_HI || state == PULSE_LO;
  assign start = state == DIR || (in_pulse && last && ok && k > 3'd1);
  dekatron_pulse_gen #(
    .STEP_HIGH(STEP_HIGH),
    .STEP_LOW (STEP_LOW),
    .SETTLE   (SETTLE)
  ) u_pulse (
    .Clk  (Clk),
    .Rst  (Rst),
    .Start(start),
    .Step (Step),
    .Last (last)
  );
  always_ff @(posedge Clk)
    if (Rst) begin
      state <= IDLE;
      tgt <= '0;
      pos <= '0;
      k <= '0;
      Reverse <= 1'b0;
      Busy <= 1'b0;
      Done <= 1'b0;
      Error <= 1'b0;
      Value <= '0;
    end else begin
      Value <= cur;
      case (state)
        IDLE:
          if (Request) begin
            tgt <= Target;
            Error <= 1'b0;
            Busy <= 1'b1;
            state <= DECODE;
          end
        DECODE:
          if (cur == 4'hF || tgt > 4'd9) begin
            Error <= 1'b1;
            Busy <= 1'b0;
            state <= FAULT;
          end else if (d == 4'd0) begin
            Done <= 1'b1;
            Busy <= 1'b0;
            state <= DONE;
          end else begin
            // a tie at five goes forward
            pos <= cur;
            k <= (d <= 4'd5) ? 3'(d) : 3'(4'd10 - d);
            Reverse <= d > 4'd5;
            state <= DIR;
          end
        DIR: state <= PULSE_HI;
        PULSE_HI, PULSE_LO:
          if (last) begin
            pos <= nxt;
            k <= k - 3'd1;
            if (!ok) begin
              Error <= 1'b1;
              Busy <= 1'b0;
              Reverse <= 1'b0;
              state <= FAULT;
            end else if (k == 3'd1) begin
              Done <= 1'b1;
              Busy <= 1'b0;
              Reverse <= 1'b0;
              state <= DONE;
            end else
              state <= PULSE_HI;
          end else if (state == PULSE_HI && !Step)
            state <= PULSE_LO;
        DONE: begin
          Done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
